// File: rtl/redmule_mx_decode_arbiter.sv
// Round-robin arbiter that lends the shared MX decoder to the X or W stream for
// one burst at a time, tracking issued and returned beats until the burst drains.
module redmule_mx_decode_arbiter #(
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               mx_enable_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               x_req_i,
  input  logic               w_req_i,
  input  logic               dec_in_fire_i,
  input  logic               dec_out_fire_i,
  output logic               sel_x_o,
  output logic               sel_w_o,
  output logic               target_is_x_o,
  output logic               target_is_w_o,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_X,
    GRANT_W,
    DRAIN_X,
    DRAIN_W
  } state_e;

  state_e             state_q, state_d;
  logic [BURST_W-1:0] in_cnt_q, in_cnt_d;
  logic [BURST_W-1:0] out_cnt_q, out_cnt_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               prefer_w_q, prefer_w_d;
  logic               err_q, err_d;

  logic [BURST_W-1:0] eff_len;
  logic               in_inc, out_inc;
  logic [BURST_W-1:0] in_nxt, out_nxt;
  logic [BURST_W:0]   out_would_be;
  logic               grant_w;

  assign eff_len      = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
  assign in_inc       = dec_in_fire_i && (in_cnt_q < len_q);
  assign out_inc      = dec_out_fire_i && (out_cnt_q < len_q);
  assign in_nxt       = in_cnt_q + BURST_W'(in_inc);
  assign out_nxt      = out_cnt_q + BURST_W'(out_inc);
  // Unsaturated view of the returned-beat count, used to flag over-delivery.
  assign out_would_be = {1'b0, out_cnt_q} + (BURST_W+1)'(dec_out_fire_i);
  assign grant_w      = w_req_i && (!x_req_i || prefer_w_q);

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    len_d      = len_q;
    prefer_w_d = prefer_w_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (dec_in_fire_i || dec_out_fire_i) err_d = 1'b1;
        if (mx_enable_i && (x_req_i || w_req_i)) begin
          state_d   = grant_w ? GRANT_W : GRANT_X;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          len_d     = eff_len;
        end
      end
      GRANT_X, GRANT_W: begin
        in_cnt_d  = in_nxt;
        out_cnt_d = out_nxt;
        if (out_would_be > {1'b0, in_nxt}) err_d = 1'b1;
        if (in_inc && (in_nxt == len_q)) begin
          if (out_nxt == len_q) begin
            state_d    = IDLE;
            prefer_w_d = (state_q == GRANT_X);
          end else begin
            state_d = (state_q == GRANT_X) ? DRAIN_X : DRAIN_W;
          end
        end
      end
      DRAIN_X, DRAIN_W: begin
        out_cnt_d = out_nxt;
        if (dec_in_fire_i || (out_would_be > {1'b0, in_cnt_q})) err_d = 1'b1;
        if (out_inc && (out_nxt == len_q)) begin
          state_d    = IDLE;
          prefer_w_d = (state_q == DRAIN_X);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      len_q      <= BURST_W'(1);
      prefer_w_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      len_q      <= len_d;
      prefer_w_q <= prefer_w_d;
      err_q      <= err_d;
    end
  end

  assign sel_x_o       = (state_q == GRANT_X);
  assign sel_w_o       = (state_q == GRANT_W);
  assign target_is_x_o = (state_q == GRANT_X) || (state_q == DRAIN_X);
  assign target_is_w_o = (state_q == GRANT_W) || (state_q == DRAIN_W);
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_redmule_mx_decode_arbiter.sv
// Directed bench for the MX decode arbiter: outputs are packed as
// {sel_x, sel_w, target_x, target_w, busy, err} and compared against constants.
module tb_redmule_mx_decode_arbiter;

  localparam int BURST_W = 8;

  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_GX   = 5'b10101;
  localparam logic [4:0] O_GW   = 5'b01011;
  localparam logic [4:0] O_DX   = 5'b00101;
  localparam logic [4:0] O_DW   = 5'b00011;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               clear_i;
  logic               mx_enable_i;
  logic [BURST_W-1:0] burst_len_i;
  logic               x_req_i;
  logic               w_req_i;
  logic               dec_in_fire_i;
  logic               dec_out_fire_i;
  logic               sel_x_o;
  logic               sel_w_o;
  logic               target_is_x_o;
  logic               target_is_w_o;
  logic               busy_o;
  logic               err_o;

  int vectors = 0;
  int miscompares = 0;

  redmule_mx_decode_arbiter #(.BURST_W(BURST_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .mx_enable_i    (mx_enable_i),
    .burst_len_i    (burst_len_i),
    .x_req_i        (x_req_i),
    .w_req_i        (w_req_i),
    .dec_in_fire_i  (dec_in_fire_i),
    .dec_out_fire_i (dec_out_fire_i),
    .sel_x_o        (sel_x_o),
    .sel_w_o        (sel_w_o),
    .target_is_x_o  (target_is_x_o),
    .target_is_w_o  (target_is_w_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns past it before checking or driving.
  task automatic applyStimulus(input logic in_fire, input logic out_fire);
    dec_in_fire_i  = in_fire;
    dec_out_fire_i = out_fire;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] base, input logic exp_err);
    logic [5:0] observed;
    logic [5:0] expected;
    observed = {sel_x_o, sel_w_o, target_is_x_o, target_is_w_o, busy_o, err_o};
    expected = {base, exp_err};
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; mx_enable_i = 1'b0; burst_len_i = '0;
    x_req_i = 1'b0; w_req_i = 1'b0; dec_in_fire_i = 1'b0; dec_out_fire_i = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst_i = 1'b0;
    checkOutput("reset", O_IDLE, 1'b0);

    // Single X burst of 4 with a mid-burst length change that must be ignored.
    mx_enable_i = 1'b1; burst_len_i = 8'd4; x_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("b4_grant_x", O_GX, 1'b0);
    x_req_i = 1'b0; burst_len_i = 8'd1; mx_enable_i = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("b4_in1_len_ignored", O_GX, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("b4_in3", O_GX, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("b4_drain", O_DX, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("b4_out3", O_DX, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("b4_idle", O_IDLE, 1'b0);

    // Round-robin with both requests held: X, W, X with an IDLE gap each time.
    doReset();
    mx_enable_i = 1'b1; burst_len_i = 8'd2; x_req_i = 1'b1; w_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("rr_grant1_x", O_GX, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rr_gap1", O_IDLE, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rr_grant2_w", O_GW, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rr_drain2_w", O_DW, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rr_gap2", O_IDLE, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rr_grant3_x", O_GX, 1'b0);
    x_req_i = 1'b0; w_req_i = 1'b0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rr_done3", O_IDLE, 1'b0);

    // Zero length acts as one; X alone wins although W is preferred now.
    burst_len_i = 8'd0; x_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("len0_grant_x", O_GX, 1'b0);
    x_req_i = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("len0_drain", O_DX, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("len0_idle", O_IDLE, 1'b0);

    // Length 1 with both fires together: GRANT_X straight back to IDLE.
    burst_len_i = 8'd1; x_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("len1_grant_x", O_GX, 1'b0);
    x_req_i = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("len1_no_drain", O_IDLE, 1'b0);

    // Clear mid-burst in GRANT_W; the next contested arbitration must pick X.
    burst_len_i = 8'd4; w_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("clr_grant_w", O_GW, 1'b0);
    w_req_i = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clr_in2", O_GW, 1'b0);
    clear_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("clr_idle", O_IDLE, 1'b0);
    clear_i = 1'b0; x_req_i = 1'b1; w_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("clr_prefers_x", O_GX, 1'b0);
    x_req_i = 1'b0; w_req_i = 1'b0;

    // Sticky error from an out-fire in IDLE; state machine keeps working.
    doReset();
    checkOutput("err_reset", O_IDLE, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("err_set", O_IDLE, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("err_held", O_IDLE, 1'b1);
    burst_len_i = 8'd2; x_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("err_grant_x", O_GX, 1'b1);
    x_req_i = 1'b0;
    clear_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    clear_i = 1'b0;
    checkOutput("err_cleared", O_IDLE, 1'b0);

    // Out-fire ahead of any in-fire during a grant is a protocol error.
    x_req_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    x_req_i = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("err_out_ahead", O_GX, 1'b1);
    doReset();
    checkOutput("err_rst_clears", O_IDLE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/redmule_mx_decode_arbiter.md
REDMULE_MX_DECODE_ARBITER -- requirements
Module: redmule_mx_decode_arbiter

Interface
REQ-001 SHALL have parameter BURST_W, default 8, width of burst length and beat counters.
REQ-002 SHALL have clk_i, input, 1, clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have clear_i, input, 1, synchronous soft clear with the same effect as rst_i.
REQ-005 SHALL have mx_enable_i, input, 1, MX decode mode enable.
REQ-006 SHALL have burst_len_i, input, BURST_W, decoded beats per grant; value 0 is treated as 1.
REQ-007 SHALL have x_req_i, input, 1, a packed X MX block is available.
REQ-008 SHALL have w_req_i, input, 1, a packed W MX block is available.
REQ-009 SHALL have dec_in_fire_i, input, 1, decoder accepted one input beat this cycle.
REQ-010 SHALL have dec_out_fire_i, input, 1, a decoded beat was accepted downstream this cycle.
REQ-011 SHALL have sel_x_o and sel_w_o, output, 1 each, decoder input source select.
REQ-012 SHALL have target_is_x_o and target_is_w_o, output, 1 each, decoded-output routing to the X/W input mux.
REQ-013 SHALL have busy_o, output, 1, high when state is not IDLE.
REQ-014 SHALL have err_o, output, 1, sticky protocol error flag.

Function
REQ-015 SHALL implement the states IDLE, GRANT_X, GRANT_W, DRAIN_X and DRAIN_W.
REQ-016 SHALL, in IDLE, leave all sel_* and target_* outputs low.
REQ-017 SHALL sample mx_enable_i only in IDLE; a grant starts only if mx_enable_i=1 and x_req_i or w_req_i is high.
REQ-018 SHALL arbitrate round-robin: if both requests are high, grant the stream not served last; after reset, X has priority.
REQ-019 SHALL, when only one request is high, grant that stream regardless of the round-robin pointer.
REQ-020 SHALL register the grant: a request seen in IDLE at cycle t gives GRANT_* from cycle t+1.
REQ-021 SHALL, in GRANT_s, drive sel_s_o=1 and target_is_s_o=1, with the other stream's outputs at 0.
REQ-022 SHALL, in GRANT_s, count input beats: in_cnt is cleared on grant and increments on each dec_in_fire_i.
REQ-023 SHALL move from GRANT_s to DRAIN_s on the cycle where dec_in_fire_i brings in_cnt to the effective burst_len.
REQ-024 SHALL drop sel_s_o from the first DRAIN cycle; no further input beats are issued for this grant.
REQ-025 SHALL, in DRAIN_s, keep target_is_s_o=1 and sel_*=0.
REQ-026 SHALL keep an out_cnt that is cleared on grant and increments on dec_out_fire_i in both GRANT_s and DRAIN_s.
REQ-027 SHALL move from DRAIN_s to IDLE on the cycle where dec_out_fire_i brings out_cnt to the effective burst_len, then set the round-robin pointer to s.
REQ-028 SHALL allow both fire inputs to be high in the same cycle; both counters update in that cycle.
REQ-029 SHALL return to IDLE from GRANT_s if out_cnt also reaches burst_len in the same cycle as in_cnt does; DRAIN_s is skipped.
REQ-030 SHALL insert at least one IDLE cycle between consecutive grants.
REQ-031 SHALL ignore changes to burst_len_i outside IDLE; the value is latched at grant time.
REQ-032 SHALL ignore request drops during GRANT_s; the grant holds until the burst completes.
REQ-033 SHALL ignore mx_enable_i deassertion mid-burst; the burst completes normally.
REQ-034 SHALL set err_o, and keep it set, on dec_out_fire_i in IDLE, on dec_in_fire_i in IDLE or DRAIN_*, or whenever out_cnt would exceed in_cnt.
REQ-035 SHALL not change the state transitions when err_o is set.
REQ-036 SHALL not wrap either counter: counters saturate at the latched burst length.

Reset
REQ-037 SHALL, on rst_i or clear_i, force IDLE, clear in_cnt, out_cnt and err_o, set the round-robin pointer to prefer X, and drive all outputs to 0 in the following cycle.
REQ-038 SHALL apply reset or clear mid-burst without completing the burst; outstanding beats are discarded.
REQ-039 SHALL give rst_i/clear_i priority over every simultaneous event.

Verification
REQ-040 SHALL be covered by: mx_enable=1, burst_len=4, x_req only, 4 in-fires then 4 out-fires -> GRANT_X for 4 fires, then DRAIN_X, then IDLE; target_is_x high throughout; busy low after the 4th out-fire.
REQ-041 SHALL be covered by: both requests held high, burst_len=2, three bursts -> grants X, W, X, with one IDLE cycle between bursts.
REQ-042 SHALL be covered by: burst_len=0 -> behaves as 1; grant released after a single in-fire and out-fire.
REQ-043 SHALL be covered by: in-fire and out-fire together on the last beat with burst_len=1 -> direct GRANT_X to IDLE, no DRAIN cycle.
REQ-044 SHALL be covered by: clear_i at in_cnt=2 in GRANT_W -> next cycle IDLE, all outputs 0, next arbitration prefers X.
REQ-045 SHALL be covered by: out-fire in IDLE -> err_o=1 and held; cleared only by rst_i or clear_i.
